// File: rtl/tt_um_mult_deser.sv
// Deserializer for the bit-serial ternary multiplier: rebuilds LSB-first row results into parallel words.
// Optional MULT_DESER_SIGN_EXT_EN widens each row field to 16 bits, sign-extended at the output load.

module tt_um_mult_deser_lane #(
  parameter int OUT_BITS = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift_en,
  input  logic                sin,
  output logic [OUT_BITS-1:0] word
);
  // Holds the OUT_BITS-1 bits collected so far; the live serial bit completes the word.
  logic [OUT_BITS-2:0] sh;

  assign word = {sin, sh};

  always_ff @(posedge clk) begin
    if (rst || clr)    sh <= '0;
    else if (shift_en) sh <= word[OUT_BITS-1:1];
  end
endmodule

module tt_um_mult_deser #(
  parameter int MAX_OUT_LEN = 4,
  parameter int OUT_BITS    = 11,
  parameter int CNT_W       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ui_frame_start,
  input  logic [MAX_OUT_LEN-1:0]    ui_serial,
  input  logic                      ui_ready,
  input  logic                      ui_clr_err,
`ifdef MULT_DESER_SIGN_EXT_EN
  output logic [MAX_OUT_LEN*16-1:0] uo_data,
`else
  output logic [MAX_OUT_LEN*OUT_BITS-1:0] uo_data,
`endif
  output logic                      uo_valid,
  output logic                      uo_busy,
  output logic                      uo_overrun,
  output logic                      uo_abort
);
`ifdef MULT_DESER_SIGN_EXT_EN
  localparam int FW = 16;
`else
  localparam int FW = OUT_BITS;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_BITS - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                                   state_q, state_d;
  logic [CNT_W-1:0]                         cnt_q, cnt_d;
  logic                                     shift_en, sh_clr, done, abort_ev;
  logic [MAX_OUT_LEN-1:0][OUT_BITS-1:0]     word;
  logic [MAX_OUT_LEN-1:0][FW-1:0]           ld, data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    sh_clr   = 1'b0;
    done     = 1'b0;
    abort_ev = 1'b0;
    case (state_q)
      IDLE: if (ui_frame_start) begin
        state_d = COLLECT;
        cnt_d   = '0;
        sh_clr  = 1'b1;
      end
      COLLECT: begin
        if (cnt_q == LAST) begin
          // Word is taken from the live serial bit; clear the lanes for the next frame.
          done    = 1'b1;
          sh_clr  = 1'b1;
          cnt_d   = '0;
          state_d = ui_frame_start ? COLLECT : IDLE;
        end else if (ui_frame_start) begin
          abort_ev = 1'b1;
          sh_clr   = 1'b1;
          cnt_d    = '0;
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar r = 0; r < MAX_OUT_LEN; r++) begin : g_lane
    tt_um_mult_deser_lane #(.OUT_BITS(OUT_BITS)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (sh_clr),
      .shift_en (shift_en),
      .sin      (ui_serial[r]),
      .word     (word[r])
    );
`ifdef MULT_DESER_SIGN_EXT_EN
    assign ld[r] = {{(FW-OUT_BITS){word[r][OUT_BITS-1]}}, word[r]};
`else
    assign ld[r] = word[r];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      uo_valid   <= 1'b0;
      uo_overrun <= 1'b0;
      uo_abort   <= 1'b0;
    end else begin
      if (done) begin
        data_q   <= ld;
        uo_valid <= 1'b1;
      end else if (ui_ready) begin
        uo_valid <= 1'b0;
      end
      // Error events win over a simultaneous clear.
      uo_overrun <= (done && uo_valid && !ui_ready) || (uo_overrun && !ui_clr_err);
      uo_abort   <= abort_ev || (uo_abort && !ui_clr_err);
    end
  end

  assign uo_data = data_q;
  assign uo_busy = (state_q == COLLECT);
endmodule

// File: tb/tb_tt_um_mult_deser.sv
// Scoreboard bench for tt_um_mult_deser: frames are scheduled per cycle, expected words queued by load cycle.
module tb_tt_um_mult_deser;
  localparam int NR = 4;
  localparam int OB = 11;
`ifdef MULT_DESER_SIGN_EXT_EN
  localparam int FW = 16;
`else
  localparam int FW = OB;
`endif

  typedef logic [NR-1:0][OB-1:0] words_t;
  typedef struct {
    int                  cyc;
    logic [NR*FW-1:0]    data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ui_frame_start = 1'b0;
  logic [NR-1:0]     ui_serial = '0;
  logic              ui_ready = 1'b0;
  logic              ui_clr_err = 1'b0;
  logic [NR*FW-1:0]  uo_data;
  logic              uo_valid, uo_busy, uo_overrun, uo_abort;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_valid = 1'b0;

  exp_t          exp_q[$];
  logic [NR-1:0] ser_at[int];
  bit            fs_at[int];

  tt_um_mult_deser dut (
    .clk(clk), .rst(rst), .ui_frame_start(ui_frame_start), .ui_serial(ui_serial),
    .ui_ready(ui_ready), .ui_clr_err(ui_clr_err), .uo_data(uo_data), .uo_valid(uo_valid),
    .uo_busy(uo_busy), .uo_overrun(uo_overrun), .uo_abort(uo_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // Expected output word: each row value sign-extended (or not) into its field.
  function automatic logic [NR*FW-1:0] mk(input words_t w);
    logic [NR*FW-1:0] e;
    e = '0;
    for (int r = 0; r < NR; r++) e[r*FW +: FW] = FW'($signed(w[r]));
    return e;
  endfunction

  function automatic words_t rnd_words();
    words_t w;
    for (int r = 0; r < NR; r++) w[r] = OB'($urandom);
    return w;
  endfunction

  // Frame starting in cycle t: bit k of each row is on the serial pins at t+1+k; word valid at t+OB+1.
  task automatic sched(input int t, input words_t w, input bit push);
    logic [NR-1:0] v;
    exp_t e;
    fs_at[t] = 1'b1;
    for (int k = 0; k < OB; k++) begin
      for (int r = 0; r < NR; r++) v[r] = w[r][k];
      ser_at[t + 1 + k] = v;
    end
    if (push) begin
      e.cyc  = t + OB + 1;
      e.data = mk(w);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Driver: frame_start and serial bits from the schedule; unscheduled serial cycles carry noise.
  always @(negedge clk) begin
    ui_frame_start = fs_at.exists(cyc);
    ui_serial      = ser_at.exists(cyc) ? ser_at[cyc] : NR'($urandom);
  end

  // Monitor: compares every expected load and flags any valid that appears without one.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missed_word act=none req=%0h (due %0d)", exp_q[0].data, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      checks++;
      if (!(uo_valid === 1'b1 && uo_data === exp_q[0].data)) begin
        errors++;
        $display("FAIL word act=%b/%0h req=1/%0h (cycle %0d)", uo_valid, uo_data, exp_q[0].data, cyc);
      end
      void'(exp_q.pop_front());
    end else if (uo_valid === 1'b1 && prev_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL spurious_valid act=1 req=0 (cycle %0d)", cyc);
    end
    prev_valid = uo_valid;
  end

  initial begin
    int T, t, last;
    words_t wa, wb;

    // Reset state
    wait_cyc(2);
    chk("rst_data", 64'(uo_data), 64'd0);
    chk("rst_valid", 64'(uo_valid), 64'd0);
    chk("rst_busy", 64'(uo_busy), 64'd0);
    chk("rst_overrun", 64'(uo_overrun), 64'd0);
    chk("rst_abort", 64'(uo_abort), 64'd0);
    rst = 1'b0;

    // Single frame with held output
    T = cyc + 2;
    wa[0] = 11'h7FB; wa[1] = 11'h005; wa[2] = 11'h000; wa[3] = 11'h3FF;
    sched(T, wa, 1'b1);
    wait_cyc(T);      chk("single_busy_T", 64'(uo_busy), 64'd0);
    wait_cyc(T + 1);  chk("single_busy_T1", 64'(uo_busy), 64'd1);
    wait_cyc(T + 11); chk("single_valid_T11", 64'(uo_valid), 64'd0);
    wait_cyc(T + 12); chk("single_busy_T12", 64'(uo_busy), 64'd0);
    wait_cyc(T + 15);
    chk("single_hold_valid", 64'(uo_valid), 64'd1);
    chk("single_hold_data", 64'(uo_data), 64'(mk(wa)));
    ui_ready = 1'b1;
    wait_cyc(T + 16); chk("single_accept", 64'(uo_valid), 64'd0);
    ui_ready = 1'b0;

    // Back-to-back frames, always ready
    T = cyc + 3;
    wa = rnd_words();
    for (int r = 0; r < NR; r++) wb[r] = '1;
    sched(T, wa, 1'b1);
    sched(T + 11, wb, 1'b1);
    ui_ready = 1'b1;
    for (int c = T + 1; c <= T + 22; c++) begin
      wait_cyc(c); chk("b2b_busy", 64'(uo_busy), 64'd1);
    end
    wait_cyc(T + 23); chk("b2b_busy_end", 64'(uo_busy), 64'd0);
    wait_cyc(T + 24);
    chk("b2b_valid", 64'(uo_valid), 64'd0);
    chk("b2b_overrun", 64'(uo_overrun), 64'd0);
    chk("b2b_abort", 64'(uo_abort), 64'd0);

    // Overrun then clear
    ui_ready = 1'b0;
    T = cyc + 3;
    sched(T, rnd_words(), 1'b1);
    sched(T + 11, rnd_words(), 1'b1);
    wait_cyc(T + 22); chk("ovr_before", 64'(uo_overrun), 64'd0);
    wait_cyc(T + 23); chk("ovr_set", 64'(uo_overrun), 64'd1);
    wait_cyc(T + 24); chk("ovr_sticky", 64'(uo_overrun), 64'd1);
    ui_clr_err = 1'b1;
    wait_cyc(T + 25);
    ui_clr_err = 1'b0;
    chk("ovr_clr", 64'(uo_overrun), 64'd0);
    chk("ovr_valid", 64'(uo_valid), 64'd1);
    ui_ready = 1'b1;
    wait_cyc(T + 26); chk("ovr_drain", 64'(uo_valid), 64'd0);
    ui_ready = 1'b0;

    // Abort: restart at T+5, clear in the same cycle loses to the set
    T = cyc + 3;
    sched(T, rnd_words(), 1'b0);
    sched(T + 5, rnd_words(), 1'b1);
    wait_cyc(T + 5); ui_clr_err = 1'b1;
    wait_cyc(T + 6);
    ui_clr_err = 1'b0;
    chk("abort_set", 64'(uo_abort), 64'd1);
    chk("abort_busy", 64'(uo_busy), 64'd1);
    wait_cyc(T + 17); chk("abort_valid", 64'(uo_valid), 64'd1);
    ui_ready = 1'b1;
    wait_cyc(T + 18);
    chk("abort_drain", 64'(uo_valid), 64'd0);
    ui_ready = 1'b0; ui_clr_err = 1'b1;
    wait_cyc(T + 19);
    ui_clr_err = 1'b0;
    chk("abort_clr", 64'(uo_abort), 64'd0);

    // Completion coinciding with accept
    T = cyc + 3;
    sched(T, rnd_words(), 1'b1);
    sched(T + 11, rnd_words(), 1'b1);
    wait_cyc(T + 22); ui_ready = 1'b1;
    wait_cyc(T + 23);
    ui_ready = 1'b0;
    chk("acc_valid", 64'(uo_valid), 64'd1);
    chk("acc_overrun", 64'(uo_overrun), 64'd0);
    ui_ready = 1'b1;
    wait_cyc(T + 24); chk("acc_drain", 64'(uo_valid), 64'd0);
    ui_ready = 1'b0;

    // Reset mid-frame (abort flag set first), then a clean frame
    T = cyc + 3;
    sched(T, rnd_words(), 1'b0);
    sched(T + 3, rnd_words(), 1'b0);
    wait_cyc(T + 5); chk("rmid_abort", 64'(uo_abort), 64'd1);
    wait_cyc(T + 6); rst = 1'b1;
    wait_cyc(T + 7);
    rst = 1'b0;
    chk("rmid_data", 64'(uo_data), 64'd0);
    chk("rmid_valid", 64'(uo_valid), 64'd0);
    chk("rmid_busy", 64'(uo_busy), 64'd0);
    chk("rmid_overrun", 64'(uo_overrun), 64'd0);
    chk("rmid_abort0", 64'(uo_abort), 64'd0);
    sched(T + 20, rnd_words(), 1'b1);
    ui_ready = 1'b1;
    wait_cyc(T + 34); chk("rmid_after", 64'(uo_valid), 64'd0);

    // Randomized frames with random gaps, readiness and clears
    t = cyc + 2;
    last = t;
    for (int i = 0; i < 30; i++) begin
      sched(t, rnd_words(), 1'b1);
      last = t;
      t += ($urandom_range(0, 3) == 0) ? OB : OB + int'($urandom_range(1, 8));
    end
    for (int c = cyc; c <= last + OB + 3; c++) begin
      wait_cyc(c);
      ui_ready   = 1'($urandom);
      ui_clr_err = ($urandom_range(0, 15) == 0);
    end
    ui_ready = 1'b1; ui_clr_err = 1'b0;
    wait_cyc(cyc + 3);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
